branch_hazard_unit: RTL and testbench
=====================================

Name: branch_hazard_unit

Overview:
- Parametrised successor to the two-source branch forwarding unit in the fetch/decode path.
- Tracks in-flight register writes across TRACK_DEPTH downstream stages (stage 1 = EX, 2 = MEM, 3 = WB, ...).
- For a branch or jalr in decode, produces a per-source forwarding select and a stall request.
- Adds load-use awareness, x0 suppression, flush and pipeline-freeze handling.

Parameters:
- REG_AW, 5, register address width (matches regfile_logsize)
- TRACK_DEPTH, 3, number of downstream stages tracked; legal range 2..7
- N_SRC, 2, number of source operands checked
- FW_W, $clog2(TRACK_DEPTH+1), width of each forwarding select (derived; do not override)

Ports:
- clk  in  1  clock
- nrst  in  1  reset; synchronous, active-low
- opcode  in  opcode_size  opcode of the instruction in decode
- rs_field  in  N_SRC*REG_AW  packed source addresses; source i occupies bits [i*REG_AW +: REG_AW]
- wr_field  in  REG_AW  destination of the instruction in decode
- wr_en  in  1  instruction in decode writes wr_field
- is_load  in  1  instruction in decode is a load
- pipe_freeze  in  1  global pipeline stall; hold all tracking state
- flush  in  1  kill all in-flight instructions (taken branch or exception)
- br_fwsel  out  N_SRC*FW_W  per-source select: 0 = regfile, k = forward from stage k
- br_stall  out  1  hold the branch in decode and insert a bubble
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- State: TRACK_DEPTH entries {valid, rd, ld}; entry k describes the instruction in stage k.
- Advance, when pipe_freeze=0 and flush=0:
  - entry k <= entry k-1 for k >= 2.
  - If br_stall=1, entry 1 <= bubble (valid=0).
  - Otherwise entry 1 <= {wr_en && (wr_field != 0), wr_field, is_load}.
- pipe_freeze=1 and flush=0: all entries hold.
- flush=1: all entries valid <= 0 on the next edge; flush has priority over pipe_freeze.
- Reset (nrst=0 at posedge): all entries valid=0, rd=0, ld=0; stall_cnt=0. Reset mid-operation discards tracked writes immediately.
- Branch detect: is_br = (opcode == btype_op) || (opcode == jalr_op).
- Operand usage:
  - btype uses sources 0 and 1.
  - jalr uses source 0 only; sources >= 1 are ignored (br_fwsel = 0, no stall contribution).
  - Sources >= 2 are used by btype only if N_SRC > 2 (reserved for future formats).
- Per used source i: find the smallest k with entry k valid and rd == rs_i (youngest writer wins on multiple matches).
  - No match, or rs_i == 0: br_fwsel_i = 0, no stall contribution.
  - Match at k = 1: stall (result not yet computed); br_fwsel_i = 0.
  - Match at k = 2 with ld = 1: stall (load data not ready); br_fwsel_i = 0.
  - Otherwise: br_fwsel_i = k.
- br_stall = is_br && (any used source requests stall) && !flush.
- When br_stall=1, all br_fwsel fields are forced to 0.
- Outputs are combinational from registered state and current inputs (0-cycle latency).
- A branch that stalls re-evaluates next cycle against the advanced entries. An ALU dependency therefore costs 1 stall cycle; a load dependency costs 2.
- Non-branch opcodes: br_fwsel = 0, br_stall = 0. Entries still advance normally.

Optional Feature:
- Macro BHU_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 at each posedge where br_stall=1 and pipe_freeze=0. It saturates at 32'hFFFF_FFFF and clears on reset.
- Not defined: stall_cnt is tied to 32'h0 and no counter flops are built. The port is always present.

Test Plan:
- addi x1 (wr_en=1, rd=1), then beq x1,x5 next cycle -> br_stall=1 for 1 cycle, then br_fwsel[0]=2, br_fwsel[1]=0.
- lw x3, then beq x3,x3 next cycle -> br_stall=1 for 2 cycles, then br_fwsel = {3,3}; stall_cnt=2 with BHU_STALL_CNT_EN defined.
- addi x4, nop, nop, nop, then jalr rs1=x4 -> br_fwsel[0]=0 (beyond TRACK_DEPTH=3), br_stall=0; with rs2 field=x4, br_fwsel[1]=0.
- addi x0, then beq x0,x0 -> br_stall=0, br_fwsel=0 (x0 never tracked).
- addi x2, addi x2, then beq x2 -> br_fwsel[0]=1 triggers stall; after the stall cycle, br_fwsel[0]=2 (youngest writer wins).
- addi x6, then flush=1 together with pipe_freeze=1, then beq x6 -> br_stall=0, br_fwsel=0 (flush clears entries). nrst=0 mid-stall -> br_stall=0 the next cycle.

Source files
------------

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit
// Hazard and forwarding unit for branches (btype) and jalr in the decode stage.
// It tracks the register writes still in flight in the next TRACK_DEPTH stages
// (stage 1 = EX, 2 = MEM, 3 = WB, ...). For each source operand it returns a
// forwarding select. It asks for a stall when the value cannot be forwarded yet.
// Optional feature: define BHU_STALL_CNT_EN to build the saturating stall-cycle
// counter. Without it, stall_cnt is tied to zero.

module branch_hazard_unit #(
  parameter int REG_AW      = 5,
  parameter int TRACK_DEPTH = 3,
  parameter int N_SRC       = 2,
  parameter int OPCODE_SIZE = 7,
  parameter logic [OPCODE_SIZE-1:0] BTYPE_OP = 7'b1100011,
  parameter logic [OPCODE_SIZE-1:0] JALR_OP  = 7'b1100111,
  localparam int FW_W       = $clog2(TRACK_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [OPCODE_SIZE-1:0]  opcode,
  input  logic [N_SRC*REG_AW-1:0] rs_field,
  input  logic [REG_AW-1:0]       wr_field,
  input  logic                    wr_en,
  input  logic                    is_load,
  input  logic                    pipe_freeze,
  input  logic                    flush,
  output logic [N_SRC*FW_W-1:0]   br_fwsel,
  output logic                    br_stall,
  output logic [31:0]             stall_cnt
);

  // One tracking entry per downstream stage. Index k is the instruction in stage k.
  logic [TRACK_DEPTH:1] valid_r;
  logic [REG_AW-1:0]    rd_r [1:TRACK_DEPTH];
  logic [TRACK_DEPTH:1] ld_r;

  logic                  is_btype_s;
  logic                  is_br_s;
  logic                  stall_req_s;
  logic [N_SRC*FW_W-1:0] fwsel_s;

  assign is_btype_s = (opcode == BTYPE_OP);
  assign is_br_s    = is_btype_s || (opcode == JALR_OP);

  // Per-source lookup. The youngest matching writer decides forward or stall.
  always_comb begin : lookup
    logic [REG_AW-1:0] rs_v;
    logic              used_v;
    logic              match_v;
    logic              hit_v;
    logic              hit_ld_v;
    logic [FW_W-1:0]   hit_k_v;
    logic              stall_v;
    logic              fwd_v;
    stall_req_s = 1'b0;
    fwsel_s     = '0;
    rs_v        = '0;
    used_v      = 1'b0;
    match_v     = 1'b0;
    hit_v       = 1'b0;
    hit_ld_v    = 1'b0;
    hit_k_v     = '0;
    stall_v     = 1'b0;
    fwd_v       = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      rs_v     = rs_field[i*REG_AW +: REG_AW];
      // jalr reads only source 0. btype reads every source.
      used_v   = is_br_s && ((i == 0) || is_btype_s);
      hit_v    = 1'b0;
      hit_ld_v = 1'b0;
      hit_k_v  = '0;
      // Scan from the oldest stage to the youngest so the smallest k wins.
      for (int k = TRACK_DEPTH; k >= 1; k--) begin
        match_v  = valid_r[k] && (rd_r[k] == rs_v);
        hit_v    = match_v | hit_v;
        hit_ld_v = match_v ? ld_r[k] : hit_ld_v;
        hit_k_v  = match_v ? FW_W'(k) : hit_k_v;
      end
      // Stage 1 has not computed its result yet. A load in stage 2 has no data yet.
      stall_v = used_v && hit_v && (rs_v != '0) &&
                ((hit_k_v == FW_W'(1)) || ((hit_k_v == FW_W'(2)) && hit_ld_v));
      fwd_v   = used_v && hit_v && (rs_v != '0) && !stall_v;
      stall_req_s = stall_req_s | stall_v;
      fwsel_s[i*FW_W +: FW_W] = fwd_v ? hit_k_v : '0;
    end
  end

  assign br_stall = is_br_s && stall_req_s && !flush;
  assign br_fwsel = br_stall ? '0 : fwsel_s;

  // Tracking pipeline. Flush beats freeze. A stalled branch inserts a bubble into stage 1.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_r <= '0;
      ld_r    <= '0;
      for (int k = 1; k <= TRACK_DEPTH; k++) begin
        rd_r[k] <= '0;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else if (!pipe_freeze) begin
      for (int k = TRACK_DEPTH; k >= 2; k--) begin
        valid_r[k] <= valid_r[k-1];
        rd_r[k]    <= rd_r[k-1];
        ld_r[k]    <= ld_r[k-1];
      end
      // x0 is never tracked, so a write to x0 enters as a bubble.
      valid_r[1] <= !br_stall && wr_en && (wr_field != '0);
      rd_r[1]    <= br_stall ? '0 : wr_field;
      ld_r[1]    <= !br_stall && is_load;
    end
  end

`ifdef BHU_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Count every stall cycle the pipeline actually spends. The count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt_r <= 32'h0;
    end else if (br_stall && !pipe_freeze && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb_branch_hazard_unit
// The directed scenarios use hand-computed expectations. A randomized run follows.
// The reference model is a queue of in-flight instruction records: the front of
// the queue is stage 1. On every negedge it is compared with the DUT.
// It follows BHU_STALL_CNT_EN for the stall counter.

module tb_branch_hazard_unit;

  localparam int D  = 3;
  localparam int NS = 2;
  localparam int FW = 2;
  localparam int NF = NS * FW;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [6:0]    opcode = OP_ALU;
  logic [9:0]    rs_field = '0;
  logic [4:0]    wr_field = '0;
  logic          wr_en = 1'b0;
  logic          is_load = 1'b0;
  logic          pipe_freeze = 1'b0;
  logic          flush = 1'b0;
  logic [NF-1:0] br_fwsel;
  logic          br_stall;
  logic [31:0]   stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  ent_t        hist[$];
  logic [31:0] m_cnt = 32'h0;

  branch_hazard_unit dut (
    .clk         (clk),
    .nrst        (nrst),
    .opcode      (opcode),
    .rs_field    (rs_field),
    .wr_field    (wr_field),
    .wr_en       (wr_en),
    .is_load     (is_load),
    .pipe_freeze (pipe_freeze),
    .flush       (flush),
    .br_fwsel    (br_fwsel),
    .br_stall    (br_stall),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs, derived from the in-flight records and the current decode inputs.
  function automatic void model_eval(output logic st, output logic [NF-1:0] fw);
    logic       any;
    logic       is_bt;
    logic       is_br;
    logic [4:0] rs;
    fw    = '0;
    any   = 1'b0;
    is_bt = (opcode == OP_BR);
    is_br = is_bt || (opcode == OP_JALR);
    for (int i = 0; i < NS; i++) begin
      rs = rs_field[i*5 +: 5];
      if (is_br && ((i == 0) || is_bt) && (rs != 5'd0)) begin
        for (int k = 1; k <= D; k++) begin
          if (hist[k-1].v && (hist[k-1].rd == rs)) begin
            if ((k == 1) || ((k == 2) && hist[k-1].ld)) any = 1'b1;
            else fw[i*FW +: FW] = FW'(k);
            break;
          end
        end
      end
    end
    st = is_br && any && !flush;
    if (st) fw = '0;
  endfunction

  // Compare process. The inputs now on the pins are the ones the next posedge samples,
  // so after the checks the model advances the way the DUT will.
  always @(negedge clk) begin : model
    logic          st;
    logic [NF-1:0] fw;
    ent_t          e;
    model_eval(st, fw);
    if (chk_en) begin
      chk("stall", {31'd0, br_stall}, {31'd0, st});
      chk("fwsel", {28'd0, br_fwsel}, {28'd0, fw});
      chk("stall_cnt", stall_cnt, m_cnt);
    end
    if (!nrst) begin
      hist.delete();
      for (int i = 0; i < D; i++) hist.push_back('0);
      m_cnt = 32'h0;
    end else begin
      if (flush) begin
        for (int i = 0; i < D; i++) hist[i].v = 1'b0;
      end else if (!pipe_freeze) begin
        e.v  = !st && wr_en && (wr_field != 5'd0);
        e.rd = st ? 5'd0 : wr_field;
        e.ld = !st && is_load;
        hist.push_front(e);
        void'(hist.pop_back());
      end
`ifdef BHU_STALL_CNT_EN
      if (st && !pipe_freeze && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'h1;
`endif
    end
  end

  // Drive one decode cycle just after posedge and return 2 time units later, ready to sample.
  task automatic step(input logic [6:0] op, input logic [4:0] r0, input logic [4:0] r1,
                      input logic [4:0] wr, input logic we, input logic ld,
                      input logic frz, input logic fl);
    @(posedge clk);
    #1;
    opcode = op; rs_field = {r1, r0}; wr_field = wr; wr_en = we;
    is_load = ld; pipe_freeze = frz; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nrst = 1'b0;
    opcode = OP_ALU; rs_field = '0; wr_field = '0; wr_en = 1'b0;
    is_load = 1'b0; pipe_freeze = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) hist.push_back('0);
    repeat (2) @(posedge clk);
    #1;
    nrst   = 1'b1;
    chk_en = 1'b1;

    // Reset state: nothing is tracked and the counter is clear.
    step(OP_BR, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall", {31'd0, br_stall}, 32'd0);
    chk("rst_fwsel", {28'd0, br_fwsel}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);

    // ALU dependency: 1 stall cycle, then forward from stage 2.
    step(OP_ALU, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_BR, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_stall", {31'd0, br_stall}, 32'd1);
    step(OP_BR, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_stall2", {31'd0, br_stall}, 32'd0);
    chk("alu_fwsel", {28'd0, br_fwsel}, 32'h2);

    // Load dependency: 2 stall cycles, then forward both sources from stage 3.
    do_reset();
    step(OP_LD, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(OP_BR, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_stall_a", {31'd0, br_stall}, 32'd1);
    step(OP_BR, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_stall_b", {31'd0, br_stall}, 32'd1);
    step(OP_BR, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_stall_c", {31'd0, br_stall}, 32'd0);
    chk("ld_fwsel", {28'd0, br_fwsel}, 32'hF);
`ifdef BHU_STALL_CNT_EN
    chk("ld_cnt", stall_cnt, 32'd2);
`else
    chk("ld_cnt", stall_cnt, 32'd0);
`endif

    // jalr: forward source 0 from stage 3, ignore source 1, then the writer leaves the window.
    do_reset();
    step(OP_ALU, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_JALR, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jalr_fwsel3", {28'd0, br_fwsel}, 32'h3);
    step(OP_JALR, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jalr_fwsel_gone", {28'd0, br_fwsel}, 32'h0);
    chk("jalr_stall", {31'd0, br_stall}, 32'd0);

    // A write to x0 is never tracked.
    step(OP_ALU, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_BR, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x0_stall", {31'd0, br_stall}, 32'd0);
    chk("x0_fwsel", {28'd0, br_fwsel}, 32'h0);

    // Two writers of x2: the youngest one wins.
    step(OP_ALU, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_ALU, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_BR, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("yw_stall", {31'd0, br_stall}, 32'd1);
    step(OP_BR, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("yw_fwsel", {28'd0, br_fwsel}, 32'h2);

    // Flush together with freeze clears the tracked writes.
    step(OP_ALU, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(OP_BR, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_stall", {31'd0, br_stall}, 32'd0);
    chk("flush_fwsel", {28'd0, br_fwsel}, 32'h0);

    // Reset during a stall clears the stall on the next cycle.
    step(OP_ALU, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_BR, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_pre", {31'd0, br_stall}, 32'd1);
    nrst = 1'b0;
    step(OP_BR, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_post", {31'd0, br_stall}, 32'd0);
    nrst = 1'b1;

    // Randomized traffic over a small register set, so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 3))
        0: opcode = OP_BR;
        1: opcode = OP_JALR;
        2: opcode = OP_ALU;
        default: opcode = OP_LD;
      endcase
      rs_field    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_field    = 5'($urandom_range(0, 7));
      wr_en       = ($urandom_range(0, 3) != 0);
      is_load     = (opcode == OP_LD);
      pipe_freeze = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      nrst        = ($urandom_range(0, 99) != 0);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    opcode = OP_ALU; wr_en = 1'b0; pipe_freeze = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
